// File: rtl/usb_serial_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_serial_fifo_if
// Purpose  : CPU bus and usb_uart_core byte-pipe signals of usb_serial_fifo.
// Revision : 1.0
// ============================================================================
interface usb_serial_fifo_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;
  logic       irq;

  modport master (
    output cs, we, addr, din, uart_in_ready, uart_out_data, uart_out_valid,
    input  dout, uart_in_data, uart_in_valid, uart_out_ready, irq
  );

  modport slave (
    input  cs, we, addr, din, uart_in_ready, uart_out_data, uart_out_valid,
    output dout, uart_in_data, uart_in_valid, uart_out_ready, irq
  );
endinterface
`default_nettype wire

// File: rtl/usb_serial_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb_serial_fifo
// Purpose  : 6502-side bridge with RX/TX FIFOs, IRQs, flags and loopback.
// Revision : 1.0
// ============================================================================
module usb_serial_fifo #(
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int TX_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  usb_serial_fifo_if.slave bus
);
  localparam int c_rx_aw = $clog2(RX_DEPTH);
  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_rx_cw = c_rx_aw + 1;
  localparam int c_tx_cw = c_tx_aw + 1;
  localparam logic [c_rx_cw-1:0] c_rx_full = c_rx_cw'(RX_DEPTH);
  localparam logic [c_tx_cw-1:0] c_tx_full = c_tx_cw'(TX_DEPTH);

  logic [7:0]         r_rx_mem [RX_DEPTH];
  logic [7:0]         r_tx_mem [TX_DEPTH];
  logic [c_rx_aw-1:0] r_rx_wp, r_rx_rp;
  logic [c_tx_aw-1:0] r_tx_wp, r_tx_rp;
  logic [c_rx_cw-1:0] r_rx_cnt;
  logic [c_tx_cw-1:0] r_tx_cnt;
  logic               r_rx_ie, r_tx_ie, r_loop, r_rx_unf, r_tx_ovf, r_irq;
  logic [7:0]         r_dout;

  logic       w_rd, w_wr, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic       w_rx_flush, w_tx_flush, w_out_ready, w_in_valid, w_lb_move;
  logic       w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic       w_unf_set, w_ovf_set, w_unf_clr, w_ovf_clr, w_ctrl_wr;
  logic [7:0] w_tx_head, w_rx_wdata, w_rd_data;

  assign w_rd       = bus.cs & ~bus.we;
  assign w_wr       = bus.cs & bus.we;
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == c_rx_full);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == c_tx_full);
  assign w_ctrl_wr  = w_wr & (bus.addr == 3'd2);
  assign w_rx_flush = w_ctrl_wr & bus.din[3];
  assign w_tx_flush = w_ctrl_wr & bus.din[4];
  assign w_unf_clr  = w_wr & (bus.addr == 3'd0) & bus.din[3];
  assign w_ovf_clr  = w_wr & (bus.addr == 3'd0) & bus.din[4];
  assign w_tx_head  = r_tx_mem[r_tx_rp];

  // Pipe handshakes follow the loopback bit as registered, so a mode switch
  // takes effect only after the cycle that writes CTRL.
  assign w_out_ready = ~r_loop & ~w_rx_full;
  assign w_in_valid  = ~r_loop & ~w_tx_empty;
  // A flush on either side cancels the move so no byte is stranded mid-way.
  assign w_lb_move   = r_loop & ~w_tx_empty & ~w_rx_full & ~w_rx_flush & ~w_tx_flush;

  assign w_rx_push  = (bus.uart_out_valid & w_out_ready) | w_lb_move;
  assign w_rx_wdata = r_loop ? w_tx_head : bus.uart_out_data;
  assign w_rx_pop   = w_rd & (bus.addr == 3'd1) & ~w_rx_empty;
  assign w_unf_set  = w_rd & (bus.addr == 3'd1) & w_rx_empty;
  assign w_tx_push  = w_wr & (bus.addr == 3'd1) & ~w_tx_full;
  assign w_ovf_set  = w_wr & (bus.addr == 3'd1) & w_tx_full;
  assign w_tx_pop   = (w_in_valid & bus.uart_in_ready) | w_lb_move;

  assign bus.uart_out_ready = w_out_ready & rst_n;
  assign bus.uart_in_valid  = w_in_valid & rst_n;
  assign bus.uart_in_data   = w_tx_head;
  assign bus.dout           = r_dout;
  assign bus.irq            = r_irq;

  always_comb begin
    w_rd_data = 8'h00;
    case (bus.addr)
      3'd0:    w_rd_data = {3'b000, r_tx_ovf, r_rx_unf, w_tx_empty, ~w_tx_full, ~w_rx_empty};
      3'd1:    w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
      3'd2:    w_rd_data = {5'b00000, r_loop, r_tx_ie, r_rx_ie};
      3'd3:    w_rd_data = 8'(r_rx_cnt);
      3'd4:    w_rd_data = 8'(r_tx_cnt);
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rx_push & ~w_rx_flush) r_rx_mem[r_rx_wp] <= w_rx_wdata;
    if (w_tx_push & ~w_tx_flush) r_tx_mem[r_tx_wp] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_cnt <= r_rx_cnt + c_rx_cw'(w_rx_push) - c_rx_cw'(w_rx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else if (w_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      r_tx_cnt <= r_tx_cnt + c_tx_cw'(w_tx_push) - c_tx_cw'(w_tx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout   <= 8'h00;
      r_rx_ie  <= 1'b0;
      r_tx_ie  <= 1'b0;
      r_loop   <= 1'b0;
      r_rx_unf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_rd) r_dout <= w_rd_data;
      if (w_ctrl_wr) begin
        r_rx_ie <= bus.din[0];
        r_tx_ie <= bus.din[1];
        r_loop  <= bus.din[2];
      end
      r_rx_unf <= w_unf_set | (r_rx_unf & ~w_unf_clr);
      r_tx_ovf <= w_ovf_set | (r_tx_ovf & ~w_ovf_clr);
      r_irq    <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & (32'(r_tx_cnt) <= TX_THRESH));
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_usb_serial_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_serial_fifo
// Purpose  : Directed and randomized checks of usb_serial_fifo against a queue model.
// Revision : 1.0
// ============================================================================
module tb_usb_serial_fifo;
  localparam int RX_DEPTH  = 16;
  localparam int TX_DEPTH  = 16;
  localparam int TX_THRESH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  usb_serial_fifo_if bus ();

  usb_serial_fifo #(
    .RX_DEPTH (RX_DEPTH),
    .TX_DEPTH (TX_DEPTH),
    .TX_THRESH(TX_THRESH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [2:0] m_ctrl;
  logic       m_unf, m_ovf, m_irq;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_ctrl = 3'b000;
    m_unf  = 1'b0;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    m_dout = 8'h00;
  endtask

  // One clock of the register-level behaviour, computed from the pre-edge state.
  task automatic model_update(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d,
                              input logic ov, input logic [7:0] od, input logic ir);
    int         rxn = rx_q.size();
    int         txn = tx_q.size();
    bit         loop = m_ctrl[2];
    bit         rd = c && !w;
    bit         wr = c && w;
    bit         rxf = wr && a == 3'd2 && d[3];
    bit         txf = wr && a == 3'd2 && d[4];
    bit         rx_pop = 0, unf_set = 0, tx_push = 0, ovf_set = 0;
    bit         pipe_rx, pipe_tx, lb;
    logic [7:0] tx_head = (txn > 0) ? tx_q[0] : 8'h00;

    m_irq = (m_ctrl[0] && rxn > 0) || (m_ctrl[1] && txn <= TX_THRESH);
    if (rd) begin
      case (a)
        3'd0: m_dout = {3'b000, m_ovf, m_unf, txn == 0, txn < TX_DEPTH, rxn > 0};
        3'd1: begin
          if (rxn > 0) begin m_dout = rx_q[0]; rx_pop = 1; end
          else begin m_dout = 8'h00; unf_set = 1; end
        end
        3'd2: m_dout = {5'b00000, m_ctrl};
        3'd3: m_dout = 8'(rxn);
        3'd4: m_dout = 8'(txn);
        default: m_dout = 8'h00;
      endcase
    end
    if (wr && a == 3'd1) begin
      if (txn < TX_DEPTH) tx_push = 1; else ovf_set = 1;
    end
    pipe_rx = !loop && rxn < RX_DEPTH && ov;
    pipe_tx = !loop && txn > 0 && ir;
    lb      = loop && txn > 0 && rxn < RX_DEPTH && !rxf && !txf;

    if (txf) tx_q.delete();
    else begin
      if (pipe_tx || lb) void'(tx_q.pop_front());
      if (tx_push) tx_q.push_back(d);
    end
    if (rxf) rx_q.delete();
    else begin
      if (rx_pop) void'(rx_q.pop_front());
      if (pipe_rx) rx_q.push_back(od);
      else if (lb) rx_q.push_back(tx_head);
    end
    m_unf = (m_unf && !(wr && a == 3'd0 && d[3])) || unf_set;
    m_ovf = (m_ovf && !(wr && a == 3'd0 && d[4])) || ovf_set;
    if (wr && a == 3'd2) m_ctrl = d[2:0];
  endtask

  task automatic check_outputs();
    bit exp_ready = !m_ctrl[2] && rx_q.size() < RX_DEPTH;
    bit exp_valid = !m_ctrl[2] && tx_q.size() > 0;
    chk("dout", 32'(bus.dout), 32'(m_dout));
    chk("irq", 32'(bus.irq), 32'(m_irq));
    chk("out_ready", 32'(bus.uart_out_ready), 32'(exp_ready));
    chk("in_valid", 32'(bus.uart_in_valid), 32'(exp_valid));
    if (exp_valid) chk("in_data", 32'(bus.uart_in_data), 32'(tx_q[0]));
  endtask

  // Drive at the falling edge, let the DUT and model advance together, check at the next fall.
  task automatic cycle(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d,
                       input logic ov, input logic [7:0] od, input logic ir);
    bus.cs = c; bus.we = w; bus.addr = a; bus.din = d;
    bus.uart_out_valid = ov; bus.uart_out_data = od; bus.uart_in_ready = ir;
    @(posedge clk);
    model_update(c, w, a, d, ov, od, ir);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic host(input logic [7:0] b);
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, b, 1'b0);
  endtask

  task automatic rand_phase(input int n, input int pcs, input int pov, input int pir);
    for (int i = 0; i < n; i++) begin
      logic       c, w, ov, ir;
      logic [2:0] a;
      logic [7:0] d, od;
      int         r;
      c  = ($urandom_range(0, 99) < pcs);
      w  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      a  = (r < 5) ? 3'd1 : (r == 5) ? 3'd0 : (r == 6) ? 3'd2 : (r == 7) ? 3'd3 :
           (r == 8) ? 3'd4 : 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      if (c && w && a == 3'd2 && $urandom_range(0, 7) != 0) d[4:3] = 2'b00;
      ov = ($urandom_range(0, 99) < pov);
      od = 8'($urandom);
      ir = ($urandom_range(0, 99) < pir);
      cycle(c, w, a, d, ov, od, ir);
    end
  endtask

  initial begin
    int got;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 3'd0; bus.din = 8'h00;
    bus.uart_out_valid = 1'b0; bus.uart_out_data = 8'h00; bus.uart_in_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 32'h00);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    chk("rst_out_ready", 32'(bus.uart_out_ready), 32'h1);
    chk("rst_in_valid", 32'(bus.uart_in_valid), 32'h0);
    rd(3'd0); chk("status_rst", 32'(bus.dout), 32'h06);
    rd(3'd3); chk("rxlvl_rst", 32'(bus.dout), 32'h00);

    // Host bytes read back in order, then underflow flag set and cleared.
    host(8'h41); host(8'h42); host(8'h43);
    rd(3'd3); chk("rxlvl_3", 32'(bus.dout), 32'h03);
    rd(3'd1); chk("rx_0", 32'(bus.dout), 32'h41);
    rd(3'd1); chk("rx_1", 32'(bus.dout), 32'h42);
    rd(3'd1); chk("rx_2", 32'(bus.dout), 32'h43);
    rd(3'd1); chk("rx_unf_data", 32'(bus.dout), 32'h00);
    rd(3'd0); chk("status_unf", 32'(bus.dout), 32'h0E);
    wr(3'd0, 8'h08);
    rd(3'd0); chk("status_unf_clr", 32'(bus.dout), 32'h06);

    // TX overflow with the host stalled, then ordered drain.
    for (int i = 0; i < 17; i++) wr(3'd1, 8'(8'h10 + i));
    rd(3'd4); chk("txlvl_full", 32'(bus.dout), 32'h10);
    rd(3'd0); chk("status_ovf", 32'(bus.dout), 32'h10);
    got = 0;
    for (int k = 0; k < 40 && got < 16; k++) begin
      if (bus.uart_in_valid) begin
        chk("tx_order", 32'(bus.uart_in_data), 32'(8'h10 + got));
        got++;
      end
      cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    chk("tx_drained", 32'(got), 32'd16);
    wr(3'd0, 8'h10);

    // RX full back-pressure and simultaneous push/pop.
    for (int i = 0; i < 16; i++) host(8'(8'h60 + i));
    host(8'h99); chk("rx_full_ready", 32'(bus.uart_out_ready), 32'h0);
    cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 8'h99, 1'b0);
    chk("rx_full_pop", 32'(bus.dout), 32'h60);
    chk("ready_after_pop", 32'(bus.uart_out_ready), 32'h1);
    host(8'h99);
    rd(3'd1); chk("rx_pop_61", 32'(bus.dout), 32'h61);
    cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 8'h9A, 1'b0);
    rd(3'd3); chk("rxlvl_pushpop", 32'(bus.dout), 32'h0F);
    wr(3'd2, 8'h08);
    rd(3'd3); chk("rxlvl_flush", 32'(bus.dout), 32'h00);

    // Loopback with both interrupts enabled.
    wr(3'd2, 8'h07); wr(3'd1, 8'h55); wr(3'd1, 8'hAA);
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("lb_in_valid", 32'(bus.uart_in_valid), 32'h0);
    rd(3'd3); chk("lb_rxlvl", 32'(bus.dout), 32'h02);
    chk("lb_irq", 32'(bus.irq), 32'h1);
    rd(3'd1); chk("lb_rx_0", 32'(bus.dout), 32'h55);
    rd(3'd1); chk("lb_rx_1", 32'(bus.dout), 32'hAA);
    wr(3'd2, 8'h00);

    rand_phase(2000, 50, 50, 50);
    rand_phase(2000, 20, 80, 10);
    rand_phase(2000, 80, 20, 90);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 4; i++) host(8'(8'hC0 + i));
    wr(3'd2, 8'h03);
    wr(3'd1, 8'h77);
    rd(3'd1);
    bus.uart_out_valid = 1'b1; bus.uart_in_ready = 1'b0; bus.cs = 1'b1; bus.we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(bus.dout), 32'h00);
    chk("midrst_irq", 32'(bus.irq), 32'h0);
    chk("midrst_out_ready", 32'(bus.uart_out_ready), 32'h0);
    chk("midrst_in_valid", 32'(bus.uart_in_valid), 32'h0);
    model_reset();
    @(negedge clk);
    bus.cs = 1'b0; bus.uart_out_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0); chk("status_after_rst", 32'(bus.dout), 32'h06);
    rand_phase(300, 50, 50, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
